// File: rtl/snake_pkg.sv
// Shared constants and types for the snake keyboard front end: directions,
// PS/2 set-2 scan codes and the prefix decoder state encoding.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BRK       = 8'hF0;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_ARR_UP    = 8'h75;
    localparam logic [7:0] SC_ARR_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_ENTER     = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXT     = 2'b01,
        ST_BRK     = 2'b10,
        ST_EXT_BRK = 2'b11
    } dec_state_e;

    // Opposite heading: flipping the upper bit maps up<->down, right<->left.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/ps2_dir_controller_if.sv
// Bundle between the PS/2 byte source / game tick and the direction controller.
interface ps2_dir_controller_if #(
    parameter int DEPTH = 4
);
    logic [7:0]             key_code;
    logic                   key_valid;
    logic                   tick;
    logic [1:0]             cur_dir;
    logic                   dir_changed;
    logic                   pause_pulse;
    logic                   restart_pulse;
    logic                   overflow;
    logic [$clog2(DEPTH):0] queue_count;

    modport master (
        output key_code, key_valid, tick,
        input  cur_dir, dir_changed, pause_pulse, restart_pulse, overflow, queue_count
    );

    modport slave (
        input  key_code, key_valid, tick,
        output cur_dir, dir_changed, pause_pulse, restart_pulse, overflow, queue_count
    );
endinterface

// File: rtl/dir_fifo.sv
// Small circular buffer of 2-bit directions. Supports push and pop in the same
// cycle (including when full: the write lands in the slot being vacated), plus
// a synchronous flush. Exposes head (next to pop) and tail (last pushed).
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [1:0]             data_i,
    output logic [1:0]             head_o,
    output logic [1:0]             tail_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop_s;
    logic          do_push_s;

    // Qualify requests against occupancy; a full queue still accepts a push when a pop frees a slot.
    always_comb begin
        do_pop_s  = pop_i && (count_q != {CW{1'b0}});
        do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign tail_o  = mem_q[wr_ptr_q - AW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_dir_controller.sv
// Turns PS/2 scan-code bytes into snake commands: tracks E0/F0 prefixes,
// decodes WASD and arrow make codes into directions, filters reversals and
// repeats, queues directions for the game tick, and pulses pause/restart.
module ps2_dir_controller
    import snake_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_dir_controller_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    dec_state_e    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          dir_valid_s;
    logic [1:0]    dir_s;
    logic          pause_s;
    logic          restart_s;

    logic [1:0]    head_s;
    logic [1:0]    tail_s;
    logic [CW-1:0] count_s;
    logic [1:0]    ref_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_s;

    logic [1:0]    cur_dir_q;
    logic          dir_changed_q;
    logic          pause_q;
    logic          restart_q;
    logic          overflow_q;

    // Decoder state and prefix-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Prefix tracking and make-code decode; the counter only advances while waiting after a prefix.
    always_comb begin
        state_d     = state_q;
        tmo_d       = {TW{1'b0}};
        dir_valid_s = 1'b0;
        dir_s       = DIR_UP;
        pause_s     = 1'b0;
        restart_s   = 1'b0;
        if (bus.key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.key_code == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        case (bus.key_code)
                            SC_W:     begin dir_valid_s = 1'b1; dir_s = DIR_UP;    end
                            SC_D:     begin dir_valid_s = 1'b1; dir_s = DIR_RIGHT; end
                            SC_S:     begin dir_valid_s = 1'b1; dir_s = DIR_DOWN;  end
                            SC_A:     begin dir_valid_s = 1'b1; dir_s = DIR_LEFT;  end
                            SC_SPACE: pause_s   = 1'b1;
                            SC_ENTER: restart_s = 1'b1;
                            default:  dir_valid_s = 1'b0;
                        endcase
                    end
                end
                ST_EXT: begin
                    if (bus.key_code == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        case (bus.key_code)
                            SC_ARR_UP:    begin dir_valid_s = 1'b1; dir_s = DIR_UP;    end
                            SC_ARR_RIGHT: begin dir_valid_s = 1'b1; dir_s = DIR_RIGHT; end
                            SC_ARR_DOWN:  begin dir_valid_s = 1'b1; dir_s = DIR_DOWN;  end
                            SC_ARR_LEFT:  begin dir_valid_s = 1'b1; dir_s = DIR_LEFT;  end
                            default:      dir_valid_s = 1'b0;
                        endcase
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Reversal/duplicate filter against the newest pending heading, plus pop and overflow decisions.
    always_comb begin
        ref_s  = (count_s != {CW{1'b0}}) ? tail_s : cur_dir_q;
        pop_s  = 1'b0;
        push_s = 1'b0;
        ovf_s  = 1'b0;
        if (restart_s) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s = bus.tick && (count_s != {CW{1'b0}});
            if (dir_valid_s && (dir_s != ref_s) && (dir_s != dir_opposite(ref_s))) begin
                if ((count_s == FULL_CNT) && !pop_s) begin
                    ovf_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (restart_s),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (dir_s),
        .head_o  (head_s),
        .tail_o  (tail_s),
        .count_o (count_s)
    );

    // Applied heading and the one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_dir_q     <= DIR_RIGHT;
            dir_changed_q <= 1'b0;
            pause_q       <= 1'b0;
            restart_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (restart_s) begin
                cur_dir_q <= DIR_RIGHT;
            end else if (pop_s) begin
                cur_dir_q <= head_s;
            end else begin
                cur_dir_q <= cur_dir_q;
            end
            dir_changed_q <= pop_s;
            pause_q       <= pause_s;
            restart_q     <= restart_s;
            overflow_q    <= ovf_s;
        end
    end

    assign bus.cur_dir       = cur_dir_q;
    assign bus.dir_changed   = dir_changed_q;
    assign bus.pause_pulse   = pause_q;
    assign bus.restart_pulse = restart_q;
    assign bus.overflow      = overflow_q;
    assign bus.queue_count   = count_s;

endmodule

// File: tb/tb_ps2_dir_controller.sv
// Directed bench for ps2_dir_controller: expected values are queued as each
// step is driven and popped when the registered outputs are sampled.
module tb_ps2_dir_controller;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_dir_controller_if #(.DEPTH(DEPTH)) bus ();

    ps2_dir_controller #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.tick      = 1'b0;
        bus.key_code  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic with_tick);
        @(negedge clk);
        bus.key_code  = b;
        bus.key_valid = 1'b1;
        bus.tick      = with_tick;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.tick      = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_code  = 8'h00;
        bus.key_valid = 1'b0;
        bus.tick      = 1'b0;

        // reset state
        do_reset();
        expect_val("rst_cur_dir", 32'd1);   check(32'(bus.cur_dir));
        expect_val("rst_count", 32'd0);     check(32'(bus.queue_count));
        expect_val("rst_dir_changed", 32'd0); check(32'(bus.dir_changed));
        expect_val("rst_overflow", 32'd0);  check(32'(bus.overflow));
        expect_val("rst_pause", 32'd0);     check(32'(bus.pause_pulse));
        expect_val("rst_restart", 32'd0);   check(32'(bus.restart_pulse));

        // arrow code without E0 is ignored; with E0 it pushes up
        expect_val("plain75_count", 32'd0);
        send(8'h75, 1'b0);                  check(32'(bus.queue_count));
        send(8'hE0, 1'b0);
        expect_val("ext75_count", 32'd1);
        send(8'h75, 1'b0);                  check(32'(bus.queue_count));
        expect_val("tick_cur_dir", 32'd0);
        expect_val("tick_dir_changed", 32'd1);
        expect_val("tick_count", 32'd0);
        do_tick();
        check(32'(bus.cur_dir)); check(32'(bus.dir_changed)); check(32'(bus.queue_count));
        expect_val("dir_changed_one_cycle", 32'd0);
        idle(1);                            check(32'(bus.dir_changed));

        // reversal rejected, extended break discarded
        do_reset();
        expect_val("reversal_left_count", 32'd0);
        send(8'h1C, 1'b0);                  check(32'(bus.queue_count));
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        expect_val("ext_break_count", 32'd0);
        send(8'h72, 1'b0);                  check(32'(bus.queue_count));
        expect_val("after_break_idle_up", 32'd1);
        send(8'h1D, 1'b0);                  check(32'(bus.queue_count));

        // typematic repeats filtered, left accepted, right rejected as reversal of left
        send(8'h1D, 1'b0);
        expect_val("repeat_count", 32'd1);
        send(8'h1D, 1'b0);                  check(32'(bus.queue_count));
        expect_val("left_count", 32'd2);
        send(8'h1C, 1'b0);                  check(32'(bus.queue_count));
        expect_val("right_rev_count", 32'd2);
        send(8'h23, 1'b0);                  check(32'(bus.queue_count));

        // fill queue up/left/up/left, then overflow
        send(8'h1D, 1'b0);
        expect_val("fill_count", 32'd4);
        send(8'h1C, 1'b0);                  check(32'(bus.queue_count));
        expect_val("overflow_pulse", 32'd1);
        expect_val("overflow_count", 32'd4);
        send(8'h1D, 1'b0);
        check(32'(bus.overflow)); check(32'(bus.queue_count));
        expect_val("overflow_one_cycle", 32'd0);
        idle(1);                            check(32'(bus.overflow));

        // push + tick on a full queue
        expect_val("full_pushtick_count", 32'd4);
        expect_val("full_pushtick_cur_dir", 32'd0);
        expect_val("full_pushtick_dc", 32'd1);
        expect_val("full_pushtick_ovf", 32'd0);
        send(8'h1D, 1'b1);
        check(32'(bus.queue_count)); check(32'(bus.cur_dir));
        check(32'(bus.dir_changed)); check(32'(bus.overflow));

        // reset after E0 makes next byte non-extended
        do_reset();
        send(8'hE0, 1'b0);
        do_reset();
        expect_val("rst_mid_seq_count", 32'd0);
        send(8'h75, 1'b0);                  check(32'(bus.queue_count));

        // prefix timeout: E0 then long gap then 1D decoded as W
        send(8'hE0, 1'b0);
        idle(TIMEOUT + 5);
        expect_val("timeout_count", 32'd1);
        expect_val("timeout_cur_dir", 32'd1);
        send(8'h1D, 1'b0);
        check(32'(bus.queue_count)); check(32'(bus.cur_dir));

        expect_val("tick2_cur_dir", 32'd0);
        do_tick();                          check(32'(bus.cur_dir));

        // push into empty queue with simultaneous tick: not popped this cycle
        expect_val("empty_pushtick_count", 32'd1);
        expect_val("empty_pushtick_dc", 32'd0);
        expect_val("empty_pushtick_cur_dir", 32'd0);
        send(8'h1C, 1'b1);
        check(32'(bus.queue_count)); check(32'(bus.dir_changed)); check(32'(bus.cur_dir));
        expect_val("down_after_left_count", 32'd2);
        send(8'h1B, 1'b0);                  check(32'(bus.queue_count));

        // restart flushes and re-centres heading
        expect_val("restart_pulse", 32'd1);
        expect_val("restart_count", 32'd0);
        expect_val("restart_cur_dir", 32'd1);
        send(8'h5A, 1'b0);
        check(32'(bus.restart_pulse)); check(32'(bus.queue_count)); check(32'(bus.cur_dir));
        expect_val("restart_one_cycle", 32'd0);
        idle(1);                            check(32'(bus.restart_pulse));

        // pause
        expect_val("pause_pulse", 32'd1);
        send(8'h29, 1'b0);                  check(32'(bus.pause_pulse));
        expect_val("pause_one_cycle", 32'd0);
        idle(1);                            check(32'(bus.pause_pulse));

        // tick on empty queue changes nothing
        expect_val("empty_tick_dc", 32'd0);
        expect_val("empty_tick_cur_dir", 32'd1);
        do_tick();
        check(32'(bus.dir_changed)); check(32'(bus.cur_dir));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
